// File: rtl/mul_seq_arb.sv
// rtl/mul_seq_arb.sv - two-port round-robin front end for a shared shift-add multiplier
// Define MUL_SEQ_EARLY_TERM_EN to stop after the bit-length of the multiplier instead of 32 steps.
module mul_seq_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  input  logic        r1_valid,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic        r0_hi,
  input  logic        r1_hi,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic        flush,
  output logic        dp_load,
  output logic        dp_step,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [63:0] dp_product,
  output logic        done,
  output logic        done_id,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_prio, r_owner, r_hi, r_done_id;
  logic [31:0] r_a, r_b, r_result;
  logic [5:0]  r_cnt, w_n;
  logic        w_idle, w_g0, w_g1, w_accept, w_done, w_last_step;
  logic [31:0] w_sel;

  // r_prio names the port that wins when both request at once
  assign w_idle   = (r_state == S_IDLE);
  assign w_g0     = w_idle & ~flush & rst_n & r0_valid & (~r1_valid | ~r_prio);
  assign w_g1     = w_idle & ~flush & rst_n & r1_valid & (~r0_valid |  r_prio);
  assign w_accept = w_g0 | w_g1;

`ifdef MUL_SEQ_EARLY_TERM_EN
  always_comb begin
    w_n = 6'd1;
    for (int i = 0; i < 32; i++) begin
      if (r_a[i]) w_n = 6'(i + 1);
    end
  end
`else
  assign w_n = 6'd32;
`endif

  assign w_last_step = (r_cnt == (w_n - 6'd1));
  assign w_sel       = r_hi ? dp_product[63:32] : dp_product[31:0];
  assign w_done      = (r_state == S_DONE) & ~flush & rst_n;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (w_last_step) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_hi      <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_cnt     <= 6'd0;
      r_result  <= 32'd0;
      r_done_id <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_g1;
        r_prio  <= ~w_g1;
        r_a     <= w_g1 ? r1_a  : r0_a;
        r_b     <= w_g1 ? r1_b  : r0_b;
        r_hi    <= w_g1 ? r1_hi : r0_hi;
      end
      r_cnt <= (r_state == S_RUN) ? r_cnt + 6'd1 : 6'd0;
      if (w_done) begin
        r_result  <= w_sel;
        r_done_id <= r_owner;
      end
    end
  end

  assign r0_ready = w_g0;
  assign r1_ready = w_g1;
  assign dp_load  = (r_state == S_LOAD);
  assign dp_step  = (r_state == S_RUN);
  assign dp_a     = r_a;
  assign dp_b     = r_b;
  assign done     = w_done;
  assign done_id  = w_done ? r_owner : r_done_id;
  assign result   = w_done ? w_sel : r_result;
  assign busy     = ~w_idle;

endmodule

// File: tb/tb_mul_seq_arb.sv
// tb/tb_mul_seq_arb.sv - directed scoreboard bench for mul_seq_arb with a shift-add datapath model
module tb_mul_seq_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic [31:0] r0_a = 32'd0, r0_b = 32'd0, r1_a = 32'd0, r1_b = 32'd0;
  logic        r0_hi = 1'b0, r1_hi = 1'b0;
  logic        r0_ready, r1_ready;
  logic        flush = 1'b0;
  logic        dp_load, dp_step;
  logic [31:0] dp_a, dp_b;
  logic [63:0] dp_product;
  logic        done, done_id;
  logic [31:0] result;
  logic        busy;

  mul_seq_arb dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .r0_hi(r0_hi), .r1_hi(r1_hi),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .flush(flush),
    .dp_load(dp_load), .dp_step(dp_step),
    .dp_a(dp_a), .dp_b(dp_b), .dp_product(dp_product),
    .done(done), .done_id(done_id), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared shift-add datapath: one multiplier bit per step, LSB first
  logic [63:0] m_prod = 64'd0;
  logic [63:0] m_b = 64'd0;
  logic [31:0] m_a = 32'd0;
  logic [5:0]  m_idx = 6'd0;
  always @(posedge clk) begin
    if (dp_load) begin
      m_prod <= 64'd0;
      m_a    <= dp_a;
      m_b    <= {32'd0, dp_b};
      m_idx  <= 6'd0;
    end else if (dp_step) begin
      if (m_a[m_idx[4:0]]) m_prod <= m_prod + (m_b << m_idx);
      m_idx <= m_idx + 6'd1;
    end
  end
  assign dp_product = m_prod;

  typedef struct {
    logic        id;
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int n_of(input logic [31:0] a);
`ifdef MUL_SEQ_EARLY_TERM_EN
    if (a == 32'd0) return 1;
    return $clog2({32'd0, a} + 64'd1);
`else
    return 32;
`endif
  endfunction

  // caller is positioned just after a negedge; returns in the accept cycle
  task automatic accept_op(output logic gid, output int t);
    logic        got;
    logic [31:0] a, b;
    logic        hi;
    logic [63:0] p;
    exp_t        e;
    got = 1'b0; gid = 1'b0; t = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      #1;
      if (r0_ready || r1_ready) begin
        got = 1'b1;
        check("ready_onehot", r0_ready & r1_ready, 0);
        gid = r1_ready;
        t   = cyc;
        a   = gid ? r1_a : r0_a;
        b   = gid ? r1_b : r0_b;
        hi  = gid ? r1_hi : r0_hi;
        p   = {32'd0, a} * {32'd0, b};
        e.id  = gid;
        e.res = hi ? p[63:32] : p[31:0];
        e.cyc = t + 2 + n_of(a);
        sbq.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    check("accept_timeout", got, 1);
  endtask

  task automatic load_check(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    check("load_pulse", dp_load, 1);
    check("load_nostep", dp_step, 0);
    check("load_busy", busy, 1);
    check("load_dp_a", dp_a, a);
    check("load_dp_b", dp_b, b);
    check("load_noready", r0_ready | r1_ready, 0);
  endtask

  task automatic wait_done();
    logic got;
    exp_t e;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk); #1;
      if (done) got = 1'b1;
    end
    check("done_timeout", got, 1);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      check("done_id", done_id, e.id);
      check("result", result, e.res);
      check("done_cycle", cyc, e.cyc);
      check("done_no_dp", dp_load | dp_step, 0);
      @(negedge clk); #1;
      check("done_single", done, 0);
      check("result_hold", result, e.res);
      check("done_id_hold", done_id, e.id);
      check("idle_busy", busy, 0);
    end
  endtask

  logic        g;
  int          t;
  logic [31:0] prev_res;
  exp_t        dropped;

  initial begin
    // reset with both requesters active: nothing may be granted
    r0_valid = 1'b1; r1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_r0_ready", r0_ready, 0);
    check("rst_r1_ready", r1_ready, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_dp_load", dp_load, 0);
    check("rst_dp_step", dp_step, 0);
    check("rst_dp_a", dp_a, 0);
    check("rst_dp_b", dp_b, 0);

    // simultaneous requests: r0, r1, r0
    r0_a = 32'd3; r0_b = 32'd5; r0_hi = 1'b0;
    r1_a = 32'd4; r1_b = 32'd9; r1_hi = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    accept_op(g, t); check("rr_first", g, 0);
    load_check(32'd3, 32'd5);
    wait_done();
    accept_op(g, t); check("rr_second", g, 1);
    load_check(32'd4, 32'd9);
    wait_done();
    accept_op(g, t); check("rr_third", g, 0);
    load_check(32'd3, 32'd5);
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_done();

    // single requester: 6 * 7
    r0_a = 32'd6; r0_b = 32'd7; r0_hi = 1'b0; r0_valid = 1'b1;
    accept_op(g, t); check("single_r0", g, 0);
    load_check(32'd6, 32'd7);
    r0_valid = 1'b0;
    wait_done();

    // all-ones squared, high half, from r1
    r1_a = 32'hFFFF_FFFF; r1_b = 32'hFFFF_FFFF; r1_hi = 1'b1; r1_valid = 1'b1;
    accept_op(g, t); check("single_r1", g, 1);
    load_check(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    r1_valid = 1'b0;
    wait_done();

    // flush while idle blocks acceptance
    flush = 1'b1; r0_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("idle_flush_ready", r0_ready, 0);
      check("idle_flush_busy", busy, 0);
    end
    flush = 1'b0; r0_valid = 1'b0;

    // flush on the 10th RUN cycle
    prev_res = result;
    r0_a = 32'hFFFF_0000; r0_b = 32'd3; r0_hi = 1'b0;
    @(negedge clk); r0_valid = 1'b1;
    accept_op(g, t);
    load_check(32'hFFFF_0000, 32'd3);
    r0_valid = 1'b0;
    while (cyc < t + 11) @(negedge clk);
    flush = 1'b1; #1;
    check("flush_in_run", dp_step, 1);
    @(negedge clk); flush = 1'b0; #1;
    check("flush_idle", busy, 0);
    check("flush_no_done", done, 0);
    check("flush_result", result, prev_res);
    check("flush_done_id", done_id, 1);
    if (sbq.size() > 0) dropped = sbq.pop_front();
    @(negedge clk); #1;
    check("flush_still_no_done", done, 0);

    // normal request after flush
    r1_a = 32'd12345; r1_b = 32'd678; r1_hi = 1'b0; r1_valid = 1'b1;
    accept_op(g, t); check("after_flush", g, 1);
    load_check(32'd12345, 32'd678);
    r1_valid = 1'b0;
    wait_done();

    // reset mid-RUN after granting r0: pointer must favour r0 again
    r0_a = 32'h8000_0001; r0_b = 32'h11; r0_hi = 1'b1; r0_valid = 1'b1;
    accept_op(g, t);
    load_check(32'h8000_0001, 32'h11);
    while (cyc < t + 6) @(negedge clk);
    rst_n = 1'b0; r1_a = 32'd21; r1_b = 32'd2; r1_hi = 1'b0; r1_valid = 1'b1;
    #1;
    check("rst_hold_ready", r0_ready | r1_ready, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_done_id", done_id, 0);
    check("midrst_result", result, 0);
    check("midrst_dp_a", dp_a, 0);
    check("midrst_dp_b", dp_b, 0);
    check("midrst_dp_step", dp_step, 0);
    if (sbq.size() > 0) dropped = sbq.pop_front();
    accept_op(g, t); check("ptr_after_reset", g, 0);
    load_check(32'h8000_0001, 32'h11);
    r0_valid = 1'b0;
    wait_done();
    accept_op(g, t); check("r1_after_reset", g, 1);
    load_check(32'd21, 32'd2);
    r1_valid = 1'b0;
    wait_done();

    // zero multiplier: shortest run when early termination is built in
    r0_a = 32'd0; r0_b = 32'd5; r0_hi = 1'b0; r0_valid = 1'b1;
    accept_op(g, t);
    load_check(32'd0, 32'd5);
    r0_valid = 1'b0;
    wait_done();

    check("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_seq_arb.md
MUL_SEQ_ARB -- requirements
Module: mul_seq_arb

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL have ports: r0_valid, r1_valid  in  1 each  requester 0/1 has a multiply pending.
REQ-003 SHALL have ports: r0_a, r0_b, r1_a, r1_b  in  32 each  requester operands (a = multiplier, b = multiplicand).
REQ-004 SHALL have ports: r0_hi, r1_hi  in  1 each  1 = return product[63:32], 0 = product[31:0].
REQ-005 SHALL have ports: r0_ready, r1_ready  out  1 each  grant; a request is accepted on a cycle where valid & ready.
REQ-006 SHALL have ports: flush  in  1  abort any in-flight operation.
REQ-007 SHALL have ports: dp_load  out  1  load operands into the shared shift-add datapath; dp_step  out  1  advance one iteration.
REQ-008 SHALL have ports: dp_a, dp_b  out  32 each  latched operands to the datapath; dp_product  in  64  datapath accumulator.
REQ-009 SHALL have ports: done  out  1  one-cycle result pulse; done_id  out  1  owner of result; result  out  32  selected product half.
REQ-010 SHALL have ports: busy  out  1  high in every state except IDLE.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-012 SHALL assert rX_ready combinationally only in IDLE with flush=0; both ready SHALL never be high together.
REQ-013 SHALL arbitrate round-robin: single valid wins; both valid -> grant port other than last-granted owner; priority pointer favours port 0 after reset.
REQ-014 SHALL on accept register a, b, hi and owner id, update the priority pointer, go to LOAD.
REQ-015 SHALL in LOAD drive dp_load=1 for exactly one cycle with dp_a/dp_b = latched operands; dp_a/dp_b SHALL hold stable from LOAD through DONE.
REQ-016 SHALL in RUN drive dp_step=1 every cycle for N cycles, counted by a 6-bit step counter; N per REQ-028/029; exit to DONE after the Nth step.
REQ-017 SHALL in DONE pulse done=1 for one cycle, done_id = owner, result = hi ? dp_product[63:32] : dp_product[31:0], then return to IDLE.
REQ-018 SHALL give latency: accept at cycle T -> LOAD T+1 -> steps T+2..T+1+N -> done at T+2+N.
REQ-019 SHALL never assert dp_load and dp_step in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-020 SHALL hold result stable from DONE until the next DONE; done_id likewise.
REQ-021 SHALL on flush=1 in LOAD/RUN/DONE return to IDLE next cycle, suppress done, leave result unchanged, keep the priority pointer as updated at accept.
REQ-022 SHALL on flush=1 in IDLE accept nothing (ready low) and remain in IDLE.
REQ-023 SHALL ignore valid/operand changes on non-granted cycles; a requester holding valid after accept SHALL be re-arbitrated only once back in IDLE.

Reset
REQ-024 SHALL on rst_n=0 at a clock edge enter IDLE regardless of state, including mid-RUN.
REQ-025 SHALL reset values: done=0, done_id=0, result=0, busy=0, dp_load=0, dp_step=0, dp_a=0, dp_b=0, step counter=0, priority pointer=port 0.
REQ-026 SHALL keep rX_ready=0 while rst_n=0.
REQ-027 SHALL produce no done pulse for an operation interrupted by reset.

Configuration
REQ-028 SHALL, with MUL_SEQ_EARLY_TERM_EN defined, set N = max(1, bit-length of latched a), i.e. index of highest set bit + 1; a=0 -> N=1.
REQ-029 SHALL, without MUL_SEQ_EARLY_TERM_EN, use fixed N=32 for all operands.

Verification
REQ-030 SHALL cover: r0 a=6, b=7, hi=0, r1 idle -> r0_ready at T, dp_load T+1, done T+34 (macro off) / T+5 (macro on, N=3), result=42, done_id=0.
REQ-031 SHALL cover: r0 and r1 valid together twice after reset -> grants r0 then r1, then r0 again with both still valid.
REQ-032 SHALL cover: r1 a=0xFFFFFFFF, b=0xFFFFFFFF, hi=1 -> result=0xFFFFFFFE, done_id=1, N=32 in both configurations.
REQ-033 SHALL cover: flush at 10th RUN cycle -> IDLE next cycle, no done, result retains previous value, next request accepted normally.
REQ-034 SHALL cover: rst_n=0 for one cycle mid-RUN -> all outputs at reset values next cycle, no done, pointer back to port 0.
REQ-035 SHALL cover (macro on): a=0, b=5 -> one dp_step, done at T+3, result=0.
